// File: rtl/fq_pkg.sv
// Shared word type for the fair-queue arbiter and its per-lane ingress FIFOs.
package fq_pkg;
    localparam int FQ_DATA_W = 64;
    typedef logic [FQ_DATA_W-1:0] fq_word_t;
endpackage

// File: rtl/fq_fifo_mem.sv
// Storage for fq_in_fifo: flop array, synchronous write, asynchronous read.
// Latency: write lands on the clock edge; read is combinational from raddr.
// Backpressure: none; the caller only asserts we for accepted writes.
module fq_fifo_mem
    import fq_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  fq_word_t              wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output fq_word_t              rdata
);
    fq_word_t mem [1 << DEPTH_LOG2];

    // Contents are deliberately not reset; the read side gates stale data.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/fq_in_fifo.sv
// Per-flow show-ahead ingress FIFO feeding fq; FQ_IN_FIFO_WATERMARK_EN adds a max_level output.
// Latency: a word written at edge N is at fifo_data in cycle N+1; a pop exposes the next word in N+1.
// Backpressure: writes while full are dropped (sticky overflow); almost_full is an early hint.
module fq_in_fifo
    import fq_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int AF_MARGIN  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wrreq,
    input  logic [63:0]           wrdata,
    output logic                  full,
    output logic                  almost_full,
    output logic                  fifo_empty,
    output logic [63:0]           fifo_data,
    input  logic                  fifo_rdreq,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
`ifdef FQ_IN_FIFO_WATERMARK_EN
    ,
    output logic [DEPTH_LOG2:0]   max_level
`endif
);
    localparam int                 DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_L = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] AF_THR  = (DEPTH_LOG2+1)'(DEPTH - AF_MARGIN);
    localparam logic [DEPTH_LOG2:0] LVL_ONE = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2:0]   level_q;
    logic [DEPTH_LOG2:0]   level_next;
    logic                  wr_acc;
    logic                  rd_acc;
    fq_word_t              mem_rdata;

    // Flags come only from the registered level, so no request-to-output path exists.
    assign full        = (level_q == DEPTH_L);
    assign fifo_empty  = (level_q == '0);
    assign almost_full = (level_q >= AF_THR);
    assign level       = level_q;
    assign fifo_data   = fifo_empty ? '0 : mem_rdata;

    assign wr_acc = wrreq & ~full;
    assign rd_acc = fifo_rdreq & ~fifo_empty;

    always_comb begin
        level_next = level_q;
        case ({wr_acc, rd_acc})
            2'b10:   level_next = level_q + LVL_ONE;
            2'b01:   level_next = level_q - LVL_ONE;
            default: level_next = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
            level_q <= level_next;
            // A fresh error event wins over a coincident clear.
            if (wrreq && full)            overflow  <= 1'b1;
            else if (err_clr)             overflow  <= 1'b0;
            if (fifo_rdreq && fifo_empty) underflow <= 1'b1;
            else if (err_clr)             underflow <= 1'b0;
        end
    end

`ifdef FQ_IN_FIFO_WATERMARK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                        max_level <= '0;
        else if (err_clr)                max_level <= '0;
        else if (level_next > max_level) max_level <= level_next;
    end
`endif

    fq_fifo_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (wrdata),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );
endmodule

// File: tb/tb_fq_in_fifo.sv
// Bench for fq_in_fifo at DEPTH_LOG2=4, AF_MARGIN=2 against a queue-based reference.
module tb_fq_in_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wrreq = 1'b0;
    logic [63:0] wrdata = '0;
    logic        fifo_rdreq = 1'b0;
    logic        err_clr = 1'b0;
    logic        full, almost_full, fifo_empty, overflow, underflow;
    logic [63:0] fifo_data;
    logic [4:0]  level;
`ifdef FQ_IN_FIFO_WATERMARK_EN
    logic [4:0]  max_level;
    int          m_max = 0;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [63:0] q[$];
    bit          m_ovf = 0;
    bit          m_unf = 0;

    always #5 clk = ~clk;

    fq_in_fifo #(.DEPTH_LOG2(4), .AF_MARGIN(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .wrreq       (wrreq),
        .wrdata      (wrdata),
        .full        (full),
        .almost_full (almost_full),
        .fifo_empty  (fifo_empty),
        .fifo_data   (fifo_data),
        .fifo_rdreq  (fifo_rdreq),
        .level       (level),
        .overflow    (overflow),
        .underflow   (underflow),
        .err_clr     (err_clr)
`ifdef FQ_IN_FIFO_WATERMARK_EN
        ,
        .max_level   (max_level)
`endif
    );

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1, "watchdog expired");
    end

    // Reference: occupancy is the queue size; head is q[0]; flags follow from size.
    function automatic logic [73:0] exp_vec();
        int n = q.size();
        return {n == 16, n >= 14, n == 0, m_ovf, m_unf, 5'(n), (n > 0) ? q[0] : 64'd0};
    endfunction

    function automatic logic [73:0] dut_vec();
        return {full, almost_full, fifo_empty, overflow, underflow, level, fifo_data};
    endfunction

    function automatic void model_reset();
        q.delete();
        m_ovf = 0;
        m_unf = 0;
`ifdef FQ_IN_FIFO_WATERMARK_EN
        m_max = 0;
`endif
    endfunction

    // Drive one cycle of requests, advance the model at the edge, sample 1 ns later.
    task automatic tick(input logic w, input logic [63:0] d, input logic r, input logic c);
        bit was_full, was_empty;
        wrreq = w; wrdata = d; fifo_rdreq = r; err_clr = c;
        @(posedge clk);
        was_full  = (q.size() == 16);
        was_empty = (q.size() == 0);
        if (w && was_full) m_ovf = 1; else if (c) m_ovf = 0;
        if (r && was_empty) m_unf = 1; else if (c) m_unf = 0;
        if (r && !was_empty) void'(q.pop_front());
        if (w && !was_full) q.push_back(d);
`ifdef FQ_IN_FIFO_WATERMARK_EN
        if (c) m_max = 0; else if (q.size() > m_max) m_max = q.size();
`endif
        #1;
        wrreq = 0; fifo_rdreq = 0; err_clr = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
        checks++;
        if (dut_vec() !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 64'd0}) begin
            errors++; $display("FAIL reset_state got %h exp empty-only", dut_vec());
        end
        for (int i = 0; i < 5; i++) tick(1, {$urandom, $urandom}, 0, 0);
        checks++;
        if (level !== 5'd5) begin errors++; $display("FAIL reset_prefill level got %0d exp 5", level); end
        #2 rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if (fifo_empty !== 1'b1 || level !== 5'd0 || fifo_data !== 64'd0 || full !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got empty=%b level=%0d data=%h full=%b exp 1 0 0 0",
                     fifo_empty, level, fifo_data, full);
        end
        @(negedge clk) rst = 1'b1;
        tick(1, 64'hA5, 0, 0);
        checks++;
        if (fifo_data !== 64'hA5 || fifo_empty !== 1'b0) begin
            errors++; $display("FAIL first_write data got %h empty %b exp a5 0", fifo_data, fifo_empty);
        end
        tick(0, 0, 1, 0);
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 16; i++) begin
            tick(1, 64'(i), 0, 0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL fill_%0d got %h exp %h", i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (full !== 1'b1 || almost_full !== 1'b1 || level !== 5'd16) begin
            errors++; $display("FAIL fill_full got full=%b af=%b level=%0d exp 1 1 16", full, almost_full, level);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (fifo_data !== 64'(i)) begin
                errors++; $display("FAIL drain_order_%0d got %h exp %h", i, fifo_data, 64'(i));
            end
            tick(0, 0, 1, 0);
        end
        checks++;
        if (fifo_empty !== 1'b1 || fifo_data !== 64'd0) begin
            errors++; $display("FAIL drain_empty got empty=%b data=%h exp 1 0", fifo_empty, fifo_data);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) tick(1, 64'h100 + 64'(i), 0, 0);
        tick(1, 64'hDEAD, 1, 0);
        checks++;
        if (overflow !== 1'b1 || level !== 5'd15) begin
            errors++; $display("FAIL overflow_set got ovf=%b level=%0d exp 1 15", overflow, level);
        end
        tick(1, 64'h200, 0, 0);
        tick(1, 64'hBEEF, 0, 1);
        checks++;
        if (overflow !== 1'b1) begin
            errors++; $display("FAIL overflow_clr_priority got %b exp 1", overflow);
        end
        tick(0, 0, 0, 1);
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_clear got %b exp 0", overflow); end
        while (q.size() > 0) begin
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL overflow_drain got %h exp %h", dut_vec(), exp_vec());
            end
            tick(0, 0, 1, 0);
        end
    endtask

    task automatic test_underflow();
        tick(1, 64'd7, 1, 0);
        checks++;
        if (underflow !== 1'b1 || level !== 5'd1 || fifo_data !== 64'd7) begin
            errors++;
            $display("FAIL underflow got unf=%b level=%0d data=%h exp 1 1 7", underflow, level, fifo_data);
        end
        tick(0, 0, 0, 1);
        checks++;
        if (underflow !== 1'b0 || level !== 5'd1) begin
            errors++; $display("FAIL underflow_clear got unf=%b level=%0d exp 0 1", underflow, level);
        end
    endtask

    task automatic test_wrap();
        logic [63:0] prev;
        prev = 64'd7;
        for (int i = 0; i < 40; i++) begin
            logic [63:0] d;
            d = {$urandom, $urandom};
            checks++;
            if (fifo_data !== prev || level !== 5'd1) begin
                errors++; $display("FAIL wrap_%0d got data=%h level=%0d exp %h 1", i, fifo_data, level, prev);
            end
            tick(1, d, 1, 0);
            prev = d;
        end
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL wrap_end got %h exp %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic w, r, c;
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 45);
            c = ($urandom_range(0, 99) < 5);
            tick(w, {$urandom, $urandom}, r, c);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL random_%0d got %h exp %h", i, dut_vec(), exp_vec());
            end
`ifdef FQ_IN_FIFO_WATERMARK_EN
            checks++;
            if (max_level !== 5'(m_max)) begin
                errors++; $display("FAIL random_max_%0d got %0d exp %0d", i, max_level, m_max);
            end
`endif
        end
        while (q.size() > 0) tick(0, 0, 1, 0);
        tick(0, 0, 0, 1);
    endtask

`ifdef FQ_IN_FIFO_WATERMARK_EN
    task automatic test_watermark();
        for (int i = 0; i < 9; i++) tick(1, 64'(i), 0, 0);
        for (int i = 0; i < 9; i++) tick(0, 0, 1, 0);
        tick(0, 0, 0, 0);
        checks++;
        if (max_level !== 5'd9 || level !== 5'd0) begin
            errors++; $display("FAIL watermark_hold got max=%0d level=%0d exp 9 0", max_level, level);
        end
        tick(0, 0, 0, 1);
        checks++;
        if (max_level !== 5'd0) begin errors++; $display("FAIL watermark_clear got %0d exp 0", max_level); end
    endtask
`endif

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_wrap();
        test_random();
`ifdef FQ_IN_FIFO_WATERMARK_EN
        test_watermark();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
